// File: rtl/lc3_controller.sv
// Instruction sequencer for the LC3 core: FETCH/DECODE/EXECUTE, optional memory
// access, WRITEBACK and UPDATEPC, with bounded waits on the memory handshakes.
//
// state       | meaning
// ------------+-----------------------------------------------
// FETCH       | request instruction, wait for complete_instr
// DECODE      | latch opcode and nzp from IR
// EXECUTE     | resolve next step and br_taken from opcode
// MEM_IND     | indirect address read (LDI/STI)
// MEM_RD      | data read, wait for complete_data
// MEM_WR      | data write, wait for complete_data
// WRITEBACK   | register file write, one cycle
// UPDATEPC    | PC load strobe, one cycle
module lc3_controller #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic [2:0]  psr,
    input  logic        complete_instr,
    input  logic        complete_data,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatePC,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic        timeout_err,
    output logic        illegal_op
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEM_IND   = 3'd3;
    localparam logic [2:0] S_MEM_RD    = 3'd4;
    localparam logic [2:0] S_MEM_WR    = 3'd5;
    localparam logic [2:0] S_WRITEBACK = 3'd6;
    localparam logic [2:0] S_UPDATEPC  = 3'd7;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       opcode;
    logic [2:0]       nzp;
    logic             br_q;
    logic             waiting;
    logic             complete;
    logic             timeout;
    logic             op_illegal;
    logic             unused_ir;

    assign unused_ir = ^IR[8:0];

    always_comb begin
        waiting  = (state == S_FETCH) || (state == S_MEM_IND) ||
                   (state == S_MEM_RD) || (state == S_MEM_WR);
        complete = (state == S_FETCH) ? complete_instr : complete_data;
        timeout  = waiting && !complete && (wait_cnt == CNT_W'(WAIT_LIMIT));
    end

    always_comb begin
        case (opcode)
            OP_BR, OP_ADD, OP_LD, OP_ST, OP_AND, OP_LDR, OP_STR,
            OP_NOT, OP_LDI, OP_STI, OP_JMP, OP_LEA: op_illegal = 1'b0;
            default:                                 op_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (timeout)       state_nxt = S_UPDATEPC;
                else if (complete) state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT, OP_LEA: state_nxt = S_WRITEBACK;
                    OP_LD, OP_LDR:                  state_nxt = S_MEM_RD;
                    OP_ST, OP_STR:                  state_nxt = S_MEM_WR;
                    OP_LDI, OP_STI:                 state_nxt = S_MEM_IND;
                    default:                        state_nxt = S_UPDATEPC;
                endcase
            end
            S_MEM_IND: begin
                if (timeout)       state_nxt = S_UPDATEPC;
                else if (complete) state_nxt = (opcode == OP_LDI) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (timeout)       state_nxt = S_UPDATEPC;
                else if (complete) state_nxt = S_WRITEBACK;
            end
            S_MEM_WR: begin
                if (timeout || complete) state_nxt = S_UPDATEPC;
            end
            S_WRITEBACK: state_nxt = S_UPDATEPC;
            default:     state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            opcode   <= 4'b0000;
            nzp      <= 3'b000;
            br_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            // Counter restarts on entry to any waiting state, saturates while waiting.
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (waiting && (wait_cnt != '1))
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (state == S_DECODE) begin
                opcode <= IR[15:12];
                nzp    <= IR[11:9];
            end
            if (timeout)
                br_q <= 1'b0;
            else if (state == S_EXECUTE)
                br_q <= (opcode == OP_BR) ? |(nzp & psr) : (opcode == OP_JMP);
        end
    end

    assign enable_fetch     = (state == S_FETCH)     && !reset;
    assign enable_decode    = (state == S_DECODE)    && !reset;
    assign enable_execute   = (state == S_EXECUTE)   && !reset;
    assign enable_writeback = (state == S_WRITEBACK) && !reset;
    assign enable_updatePC  = (state == S_UPDATEPC)  && !reset;
    assign br_taken         = br_q && !reset;
    assign timeout_err      = timeout && !reset;
    assign illegal_op       = (state == S_EXECUTE) && op_illegal && !reset;

    always_comb begin
        mem_state = 2'b11;
        if (!reset) begin
            case (state)
                S_MEM_IND: mem_state = 2'b10;
                S_MEM_RD:  mem_state = 2'b00;
                S_MEM_WR:  mem_state = 2'b01;
                default:   mem_state = 2'b11;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_controller.sv
// Scoreboard bench for lc3_controller: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_lc3_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] IR = 16'h0000;
    logic [2:0]  psr = 3'b000;
    logic        complete_instr = 1'b0;
    logic        complete_data = 1'b0;
    logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
    logic        br_taken, timeout_err, illegal_op;
    logic [1:0]  mem_state;

    always #5 clock = ~clock;

    lc3_controller #(.WAIT_LIMIT(255), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .IR(IR), .psr(psr),
        .complete_instr(complete_instr), .complete_data(complete_data),
        .enable_fetch(enable_fetch), .enable_decode(enable_decode),
        .enable_execute(enable_execute), .enable_writeback(enable_writeback),
        .enable_updatePC(enable_updatePC), .br_taken(br_taken),
        .mem_state(mem_state), .timeout_err(timeout_err), .illegal_op(illegal_op)
    );

    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_F    = 5'b10000;
    localparam logic [4:0] EN_D    = 5'b01000;
    localparam logic [4:0] EN_E    = 5'b00100;
    localparam logic [4:0] EN_WB   = 5'b00010;
    localparam logic [4:0] EN_UPC  = 5'b00001;

    // Expected word: {F,D,E,WB,UPC, br_taken, mem_state[1:0], timeout_err, illegal_op}
    logic [9:0] exp_q[$];
    string      tag_q[$];
    logic [9:0] pend_e[$];
    logic       pend_ci[$];
    logic       pend_cd[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         sb_on = 1'b0;
    logic       cur_br = 1'b0;
    string      cur_tag = "none";
    logic [9:0] got;
    logic [9:0] want;
    string      want_tag;

    always @(negedge clock) begin
        if (sb_on) begin
            got = {enable_fetch, enable_decode, enable_execute, enable_writeback,
                   enable_updatePC, br_taken, mem_state, timeout_err, illegal_op};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_cycle: got %b, no expectation queued", got);
            end else begin
                want     = exp_q.pop_front();
                want_tag = tag_q.pop_front();
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got %b required %b", want_tag, $time, got, want);
                end
            end
        end
    end

    task automatic add(input logic [4:0] en, input logic [1:0] ms, input logic to,
                       input logic il, input logic ci, input logic cd);
        pend_e.push_back({en, cur_br, ms, to, il});
        pend_ci.push_back(ci);
        pend_cd.push_back(cd);
    endtask

    task automatic issue(input int cut);
        int n;
        n = (cut > 0 && cut < pend_e.size()) ? cut : pend_e.size();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pend_e[i]);
            tag_q.push_back(cur_tag);
        end
        for (int i = 0; i < n; i++) begin
            complete_instr = pend_ci[i];
            complete_data  = pend_cd[i];
            @(posedge clock);
            #1;
        end
        complete_instr = 1'b0;
        complete_data  = 1'b0;
        pend_e.delete();
        pend_ci.delete();
        pend_cd.delete();
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b1;
        cur_br  = 1'b0;
        cur_tag = "reset";
        for (int i = 0; i < n; i++) add(EN_NONE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(0);
        reset = 1'b0;
    endtask

    // dw < 0: complete never arrives, timeout on the 256th wait cycle
    task automatic wait_phase(input logic [1:0] ms, input int dw, input bit hold, output bit to);
        int n;
        n = (dw < 0) ? 256 : dw;
        for (int i = 1; i <= n; i++)
            add(EN_NONE, ms, (dw < 0) && (i == n), 1'b0, hold, hold || (i == dw));
        to = (dw < 0);
        if (to) cur_br = 1'b0;
    endtask

    task automatic do_instr(input string tag, input logic [15:0] ir, input logic [2:0] p,
                            input int iw, input int dw, input bit hold, input int cut);
        logic [3:0] op;
        logic [2:0] nz;
        logic       il;
        bit         to;
        int         n;
        op = ir[15:12];
        nz = ir[11:9];
        cur_tag = tag;
        IR  = ir;
        psr = p;
        n = (iw < 0) ? 256 : iw;
        for (int i = 1; i <= n; i++)
            add(EN_F, 2'b11, (iw < 0) && (i == n), 1'b0, hold || (i == iw), hold);
        if (iw < 0) begin
            cur_br = 1'b0;
            add(EN_UPC, 2'b11, 1'b0, 1'b0, hold, hold);
        end else begin
            add(EN_D, 2'b11, 1'b0, 1'b0, hold, hold);
            il = (op == 4'b0100) || (op == 4'b1000) || (op == 4'b1101) || (op == 4'b1111);
            add(EN_E, 2'b11, 1'b0, il, hold, hold);
            cur_br = (op == 4'b0000) ? |(nz & p) : (op == 4'b1100);
            case (op)
                4'b0001, 4'b0101, 4'b1001, 4'b1110: begin
                    add(EN_WB, 2'b11, 1'b0, 1'b0, hold, hold);
                end
                4'b0010, 4'b0110: begin
                    wait_phase(2'b00, dw, hold, to);
                    if (!to) add(EN_WB, 2'b11, 1'b0, 1'b0, hold, hold);
                end
                4'b0011, 4'b0111: wait_phase(2'b01, dw, hold, to);
                4'b1010: begin
                    wait_phase(2'b10, dw, hold, to);
                    if (!to) begin
                        wait_phase(2'b00, dw, hold, to);
                        if (!to) add(EN_WB, 2'b11, 1'b0, 1'b0, hold, hold);
                    end
                end
                4'b1011: begin
                    wait_phase(2'b10, dw, hold, to);
                    if (!to) wait_phase(2'b01, dw, hold, to);
                end
                default: ;
            endcase
            add(EN_UPC, 2'b11, 1'b0, 1'b0, hold, hold);
        end
        issue(cut);
    endtask

    initial begin
        @(posedge clock);
        #1;
        sb_on = 1'b1;
        do_reset(2);
        do_instr("add_seq",       16'h1042, 3'b000, 1, 0, 1'b0, 0);
        do_instr("brnp_z_nt",     16'h0A05, 3'b010, 1, 0, 1'b0, 0);
        do_instr("brnp_n_tk",     16'h0A05, 3'b100, 1, 0, 1'b0, 0);
        do_instr("br_nzp000",     16'h0000, 3'b111, 1, 0, 1'b0, 0);
        do_instr("br_nzp111",     16'h0E00, 3'b001, 1, 0, 1'b0, 0);
        do_instr("ldi_wait3",     16'hA1FF, 3'b000, 1, 3, 1'b0, 0);
        do_instr("sti_wait2",     16'hB000, 3'b000, 2, 2, 1'b0, 0);
        do_instr("ld_hold_high",  16'h2000, 3'b000, 1, 1, 1'b1, 0);
        do_instr("st_hold_high",  16'h3000, 3'b000, 1, 1, 1'b1, 0);
        do_instr("ldr",           16'h6000, 3'b000, 1, 1, 1'b0, 0);
        do_instr("str",           16'h7000, 3'b000, 1, 1, 1'b0, 0);
        do_instr("and",           16'h5000, 3'b000, 2, 0, 1'b0, 0);
        do_instr("not",           16'h9000, 3'b000, 1, 0, 1'b0, 0);
        do_instr("lea",           16'hE000, 3'b000, 3, 0, 1'b0, 0);
        do_instr("jmp",           16'hC1C0, 3'b000, 1, 0, 1'b0, 0);
        do_instr("st_timeout",    16'h3000, 3'b000, 1, -1, 1'b0, 0);
        do_instr("st_at_limit",   16'h3000, 3'b000, 1, 256, 1'b0, 0);
        do_instr("jmp_again",     16'hC1C0, 3'b000, 1, 0, 1'b0, 0);
        do_instr("fetch_timeout", 16'h1042, 3'b000, -1, 0, 1'b0, 0);
        do_instr("trap_illegal",  16'hF025, 3'b000, 1, 0, 1'b0, 0);
        do_instr("ld_aborted",    16'h2000, 3'b000, 1, 5, 1'b0, 5);
        do_reset(2);
        do_instr("add_post_rst",  16'h1042, 3'b000, 1, 0, 1'b0, 0);
        sb_on = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expect: got %0d entries pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
